// File: rtl/ace_mem_pkg.sv
// Shared definitions for the ACE core-side memory master.
package ace_mem_pkg;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b10;

    localparam logic [31:0] IO_BASE         = 32'h0010_0000;
    localparam int          DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        RMW_RD,
        RMW_WR
    } state_t;

    typedef enum logic {
        OWN_FETCH,
        OWN_DATA
    } owner_t;

    // True when a data access cannot be served by one aligned word transfer.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0])
            || ((size == SZ_WORD) && (offset != 2'b00))
            || (size == 2'b11);
    endfunction

endpackage

// File: rtl/ace_mem_lane.sv
// Big-endian lane logic: load extraction/extension and store merge.
module ace_mem_lane
    import ace_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [4:0]  shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_mask;

    // Select the addressed lane (offset 0 is the most significant) for both paths.
    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        shift      = 5'd0;
        lane_b     = 8'h0;
        lane_h     = 16'h0;
        lane_mask  = 32'h0;
        load_data  = word;
        merge_data = word;
        case (size)
            SZ_BYTE: begin
                shift      = {~offset, 3'b000};
                lane_b     = 8'(word >> shift);
                lane_mask  = 32'h0000_00FF << shift;
                load_data  = sign_ext ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
                merge_data = (word & ~lane_mask) | ({24'h0, wdata[7:0]} << shift);
            end
            SZ_HALF: begin
                shift      = {~offset[1], 4'b0000};
                lane_h     = 16'(word >> shift);
                lane_mask  = 32'h0000_FFFF << shift;
                load_data  = sign_ext ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
                merge_data = (word & ~lane_mask) | ({16'h0, wdata} << shift);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ace_mem_master.sv
// Arbitrates fetch and data requests onto the single-word ACE memory bus.
module ace_mem_master
    import ace_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_signed,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        busy,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT);

    state_t      state, state_next;
    owner_t      owner;
    logic [1:0]  addr_lo, size_q;
    logic        sign_q, we_q, mis_q;
    logic [15:0] wdata_q;
    logic [31:0] rmw_word;
    logic        rd_active, wr_active;
    logic [CNT_W-1:0] wait_cnt;

    logic        pulse, grant, g_mis, g_word_store, g_rmw;
    logic [31:0] g_addr;
    logic        ack_rd, ack_wr, timed_out;
    logic        fin, fin_err, start_wr;
    logic [31:0] lane_word, load_data, merge_data;

    // Grant decode: data wins; a new grant is held off during the completion pulse.
    assign pulse        = if_valid | d_done;
    assign grant        = (state == IDLE) & (d_req | if_req) & ~pulse;
    assign g_addr       = d_req ? d_addr : if_addr;
    assign g_mis        = d_req & misaligned(d_size, d_addr[1:0]);
    assign g_word_store = d_req & d_we & (d_size == SZ_WORD) & ~g_mis;
    assign g_rmw        = d_req & d_we & (d_size != SZ_WORD) & ~g_mis;

    // Strobes drop combinationally in the ack cycle so the responder never re-triggers.
    assign ack_rd    = rd_active & mem_ack;
    assign ack_wr    = wr_active & mem_ack;
    assign timed_out = (rd_active | wr_active) & ~mem_ack & (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign mem_read  = rd_active & ~mem_ack;
    assign mem_write = wr_active & ~mem_ack;
    assign busy      = (state != IDLE) | pulse;

    // The RMW write phase merges into the captured word; every other user sees the bus word.
    assign lane_word = (state == RMW_WR) ? rmw_word : mem_read_data;

    ace_mem_lane u_lane (
        .word       (lane_word),
        .offset     (addr_lo),
        .size       (size_q),
        .sign_ext   (sign_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_err    = 1'b0;
        start_wr   = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (g_word_store) state_next = WR;
                    else if (g_rmw)   state_next = RMW_RD;
                    else              state_next = RD;
                end
            end
            RD: begin
                if (mis_q || timed_out) begin
                    fin = 1'b1; fin_err = 1'b1; state_next = IDLE;
                end else if (ack_rd) begin
                    fin = 1'b1; state_next = IDLE;
                end
            end
            WR: begin
                if (timed_out) begin
                    fin = 1'b1; fin_err = 1'b1; state_next = IDLE;
                end else if (ack_wr) begin
                    fin = 1'b1; state_next = IDLE;
                end
            end
            RMW_RD: begin
                if (timed_out) begin
                    fin = 1'b1; fin_err = 1'b1; state_next = IDLE;
                end else if (ack_rd) begin
                    state_next = RMW_WR;
                end
            end
            RMW_WR: begin
                if (!wr_active) begin
                    start_wr = 1'b1;
                end else if (timed_out) begin
                    fin = 1'b1; fin_err = 1'b1; state_next = IDLE;
                end else if (ack_wr) begin
                    fin = 1'b1; state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction registers, bus phase control and registered completion outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: reset drops the in-flight transaction and clears every output register at once.
        if (!reset_n) begin
            owner          <= OWN_FETCH;
            addr_lo        <= 2'b00;
            size_q         <= SZ_WORD;
            sign_q         <= 1'b0;
            we_q           <= 1'b0;
            mis_q          <= 1'b0;
            wdata_q        <= 16'h0;
            rmw_word       <= 32'h0;
            rd_active      <= 1'b0;
            wr_active      <= 1'b0;
            wait_cnt       <= '0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            if_rdata       <= 32'h0;
            if_valid       <= 1'b0;
            d_rdata        <= 32'h0;
            d_done         <= 1'b0;
            d_err          <= 1'b0;
        end else begin
            // NOTE: non-blocking updates; later assignments in this block override earlier ones.
            if_valid <= 1'b0;
            d_done   <= 1'b0;
            d_err    <= 1'b0;
            if ((rd_active || wr_active) && !mem_ack) wait_cnt <= wait_cnt + 1'b1;
            if (ack_rd || ack_wr || timed_out) begin
                rd_active <= 1'b0;
                wr_active <= 1'b0;
            end
            if (grant) begin
                owner          <= d_req ? OWN_DATA : OWN_FETCH;
                addr_lo        <= g_addr[1:0];
                size_q         <= d_req ? d_size : SZ_WORD;
                sign_q         <= d_req & d_signed;
                we_q           <= d_req & d_we;
                mis_q          <= g_mis;
                wdata_q        <= d_wdata[15:0];
                mem_addr       <= {g_addr[31:2], 2'b00};
                mem_write_data <= d_wdata;
                rd_active      <= ~g_mis & ~g_word_store;
                wr_active      <= g_word_store;
                wait_cnt       <= '0;
            end
            if ((state == RMW_RD) && ack_rd) rmw_word <= mem_read_data;
            if (start_wr) begin
                wr_active      <= 1'b1;
                mem_write_data <= merge_data;
                wait_cnt       <= '0;
            end
            if (fin) begin
                if (owner == OWN_DATA) begin
                    d_done  <= 1'b1;
                    d_err   <= fin_err;
                    d_rdata <= (fin_err || we_q) ? 32'h0 : load_data;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= fin_err ? 32'h0 : load_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ace_mem_master.sv
// Directed bench for ace_mem_master with a configurable-latency bus responder.
module tb_ace_mem_master;
    import ace_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0, d_we = 1'b0, d_signed = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
    logic [31:0] d_rdata;
    logic        d_done, d_err, busy;
    logic        mem_read, mem_write, mem_ack;
    logic [31:0] mem_addr, mem_write_data;
    logic [31:0] mem_read_data = 32'h0;

    logic        resp_ack = 1'b0, stray_ack = 1'b0;
    logic        ack_en = 1'b1;
    int          ack_delay = 1;
    int          resp_wait = 0;
    logic [31:0] mem_model [0:63];
    int          rd_acks = 0, wr_acks = 0;
    logic [31:0] last_wr_data = 32'h0, last_wr_addr = 32'h0;

    int done_cnt = 0, valid_cnt = 0, rd_hi = 0, wr_hi = 0, strobe_in_ack = 0;
    int tests = 0, fails = 0;

    assign mem_ack = resp_ack | stray_ack;

    always #5 clk = ~clk;

    ace_mem_master dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .busy(busy), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ack(mem_ack)
    );

    // Responder: acks ack_delay cycles after it first sees a strobe.
    always @(posedge clk) begin
        if (resp_ack) begin
            resp_ack <= 1'b0;
        end else if (ack_en && (mem_read || mem_write)) begin
            if (resp_wait + 1 >= ack_delay) begin
                resp_ack  <= 1'b1;
                resp_wait <= 0;
                if (mem_write) begin
                    last_wr_data <= mem_write_data;
                    last_wr_addr <= mem_addr;
                    wr_acks      <= wr_acks + 1;
                end else begin
                    mem_read_data <= mem_model[mem_addr[7:2]];
                    rd_acks       <= rd_acks + 1;
                end
            end else begin
                resp_wait <= resp_wait + 1;
            end
        end else begin
            resp_wait <= 0;
        end
    end

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (d_done)   done_cnt  <= done_cnt + 1;
        if (if_valid) valid_cnt <= valid_cnt + 1;
        if (mem_read)  rd_hi <= rd_hi + 1;
        if (mem_write) wr_hi <= wr_hi + 1;
        if (mem_ack && (mem_read || mem_write)) strobe_in_ack <= strobe_in_ack + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic data_op(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input int bound,
                           output logic [31:0] rdata, output logic err, output logic done,
                           output logic busy_seen, output int lat);
        d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        lat = 0; done = 1'b0;
        while (!done && lat < bound) begin
            @(negedge clk);
            lat++;
            done = d_done;
        end
        rdata = d_rdata; err = d_err; busy_seen = busy;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        idle(2);
    endtask

    task automatic fetch_op(input logic [31:0] addr, input int bound,
                            output logic [31:0] rdata, output logic done, output int lat);
        if_addr = addr; if_req = 1'b1;
        lat = 0; done = 1'b0;
        while (!done && lat < bound) begin
            @(negedge clk);
            lat++;
            done = if_valid;
        end
        rdata = if_rdata;
        if_req = 1'b0;
        idle(2);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err, done, bsy, found;
        int          lat, s_done, s_valid, s_rd, s_wr, s_rda, s_wra, d_idx, f_idx;

        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        mem_model[4]  = 32'h1234_5678;
        mem_model[16] = 32'hDEAD_BEEF;

        // Reset state
        #3 reset_n = 1'b0;
        idle(2);
        check("reset_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("reset_flags", {27'h0, if_valid, d_done, d_err, busy, 1'b0}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_rdata", d_rdata | if_rdata | mem_write_data, 32'h0);
        reset_n = 1'b1;
        idle(2);

        // SRAM-like word load
        ack_delay = 3;
        s_done = done_cnt;
        data_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("sram_load_data", rdata, 32'h1234_5678);
        check("sram_load_err", 32'(err), 32'h0);
        check("sram_load_lat", 32'(lat), 32'd5);
        check("sram_load_busy", 32'(bsy), 32'h1);
        check("sram_load_one_pulse", 32'(done_cnt - s_done), 32'd1);

        // IO-like word load
        ack_delay = 1;
        data_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("io_load_data", rdata, 32'h1234_5678);
        check("io_load_lat", 32'(lat), 32'd3);

        // Sub-word loads, big-endian lanes
        mem_model[4] = 32'h0000_00F0;
        data_op(1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 40, rdata, err, done, bsy, lat);
        check("byte_signed", rdata, 32'hFFFF_FFF0);
        data_op(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 40, rdata, err, done, bsy, lat);
        check("byte_unsigned", rdata, 32'h0000_00F0);
        mem_model[4] = 32'h80C1_7F02;
        data_op(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("byte0_signed", rdata, 32'hFFFF_FF80);
        data_op(1'b0, SZ_BYTE, 1'b1, 32'h12, 32'h0, 40, rdata, err, done, bsy, lat);
        check("byte2_signed", rdata, 32'h0000_007F);
        data_op(1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("half0_unsigned", rdata, 32'h0000_80C1);
        data_op(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("half0_signed", rdata, 32'hFFFF_80C1);
        data_op(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, 40, rdata, err, done, bsy, lat);
        check("half2_signed", rdata, 32'h0000_7F02);

        // Half store via read-modify-write
        mem_model[8] = 32'h1122_3344;
        s_rda = rd_acks; s_wra = wr_acks; s_done = done_cnt;
        data_op(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_BEEF, 40, rdata, err, done, bsy, lat);
        check("rmw_half_data", last_wr_data, 32'h1122_BEEF);
        check("rmw_half_addr", last_wr_addr, 32'h20);
        check("rmw_half_reads", 32'(rd_acks - s_rda), 32'd1);
        check("rmw_half_writes", 32'(wr_acks - s_wra), 32'd1);
        check("rmw_half_lat", 32'(lat), 32'd6);
        check("rmw_half_one_pulse", 32'(done_cnt - s_done), 32'd1);
        data_op(1'b1, SZ_BYTE, 1'b0, 32'h21, 32'h0000_00A5, 40, rdata, err, done, bsy, lat);
        check("rmw_byte_data", last_wr_data, 32'h11A5_3344);

        // Word store: single write phase
        s_rda = rd_acks;
        data_op(1'b1, SZ_WORD, 1'b0, 32'h30, 32'hCAFE_BABE, 40, rdata, err, done, bsy, lat);
        check("store_word_data", last_wr_data, 32'hCAFE_BABE);
        check("store_word_no_read", 32'(rd_acks - s_rda), 32'd0);
        check("store_word_lat", 32'(lat), 32'd3);

        // Simultaneous data and fetch requests
        mem_model[4] = 32'h1234_5678;
        d_we = 1'b0; d_size = SZ_WORD; d_signed = 1'b0; d_addr = 32'h10; d_req = 1'b1;
        if_addr = 32'h40; if_req = 1'b1;
        d_idx = 0; f_idx = 0;
        for (int n = 1; n <= 30 && f_idx == 0; n++) begin
            @(negedge clk);
            if (d_done) begin
                d_idx = n; check("arb_data", d_rdata, 32'h1234_5678); d_req = 1'b0;
            end
            if (if_valid) begin
                f_idx = n; check("arb_fetch", if_rdata, 32'hDEAD_BEEF); if_req = 1'b0;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("arb_data_idx", 32'(d_idx), 32'd3);
        check("arb_fetch_idx", 32'(f_idx), 32'd7);
        idle(2);

        // Misaligned accesses: error pulse, no bus activity
        s_rd = rd_hi; s_wr = wr_hi;
        data_op(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 40, rdata, err, done, bsy, lat);
        check("mis_word_err", {30'h0, done, err}, 32'h3);
        check("mis_word_rdata", rdata, 32'h0);
        check("mis_word_lat", 32'(lat), 32'd2);
        data_op(1'b1, SZ_HALF, 1'b0, 32'h11, 32'h1234, 40, rdata, err, done, bsy, lat);
        check("mis_half_err", {30'h0, done, err}, 32'h3);
        data_op(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("mis_size_err", {30'h0, done, err}, 32'h3);
        check("mis_no_strobe", 32'((rd_hi - s_rd) + (wr_hi - s_wr)), 32'd0);

        // Timeouts with a responder that never acks
        ack_en = 1'b0;
        s_rd = rd_hi;
        data_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 100, rdata, err, done, bsy, lat);
        check("tmo_data_err", {30'h0, done, err}, 32'h3);
        check("tmo_data_strobe_cycles", 32'(rd_hi - s_rd), 32'd64);
        check("tmo_data_rdata", rdata, 32'h0);
        fetch_op(32'h40, 100, rdata, done, lat);
        check("tmo_fetch_valid", 32'(done), 32'h1);
        check("tmo_fetch_rdata", rdata, 32'h0);
        ack_en = 1'b1;

        // Stray ack while idle is ignored
        s_done = done_cnt; s_valid = valid_cnt; s_rd = rd_hi; s_wr = wr_hi;
        stray_ack = 1'b1;
        idle(1);
        stray_ack = 1'b0;
        idle(4);
        check("stray_ack_quiet", 32'((done_cnt - s_done) + (valid_cnt - s_valid)
                                    + (rd_hi - s_rd) + (wr_hi - s_wr)), 32'd0);

        // Asynchronous reset during the RMW write phase
        ack_delay = 3;
        mem_model[8] = 32'h1122_3344;
        d_we = 1'b1; d_size = SZ_HALF; d_signed = 1'b0; d_addr = 32'h22; d_wdata = 32'h0000_1234;
        d_req = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            found = mem_write;
        end
        check("rst_reached_rmw_wr", 32'(found), 32'h1);
        reset_n = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        check("rst_mid_strobes", {29'h0, mem_read, mem_write, busy}, 32'h0);
        check("rst_mid_bus", mem_addr | mem_write_data, 32'h0);
        check("rst_mid_outputs", {29'h0, if_valid, d_done, d_err} | d_rdata | if_rdata, 32'h0);
        idle(2);
        reset_n = 1'b1;
        s_done = done_cnt; s_valid = valid_cnt; s_rd = rd_hi; s_wr = wr_hi;
        idle(10);
        check("rst_after_quiet", 32'((done_cnt - s_done) + (valid_cnt - s_valid)
                                     + (rd_hi - s_rd) + (wr_hi - s_wr)), 32'd0);

        // Normal operation resumes after reset
        ack_delay = 1;
        data_op(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 40, rdata, err, done, bsy, lat);
        check("post_rst_load", rdata, 32'h1234_5678);
        check("strobe_low_in_ack", 32'(strobe_in_ack), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
